// File: rtl/gt1_ctx_tracker.sv
// gt1_ctx_tracker
// Per-coefficient-group sequencer upstream of the CABAC base-level calculator.
// Takes absolute levels of one 4x4 CG in reverse scan order. For every nonzero
// level it emits (one cycle later) the c1/c2 indices and greater1 context that
// were in force before that level, and pulses lvl_start. It also derives the
// CG's ctx_set from the greater1 outcome of the previous CG in the same TU.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   tu_start        new TU: clears the previous-CG greater1 flag
//   coef_valid      one coefficient this cycle (no backpressure)
//   cg_first        first coefficient of a CG (qualifies coef_valid)
//   coef_last       last coefficient of a CG (qualifies coef_valid)
//   is_luma, cg_idx CG attributes, sampled with cg_first
//   abs_level       absolute coefficient level
//   lvl_start       one-cycle pulse per nonzero coefficient
//   c1_idx, c2_idx, greater1_ctx, ctx_set, abs_level_out
//                   per-coefficient results, held between pulses
//   cg_done         one-cycle pulse at CG end, with nz_count
//   protocol_err    sticky protocol violation flag
module gt1_ctx_tracker #(
    parameter int C1FLAG_NUMBER = 8,
    parameter int CG_SIZE       = 16,
    parameter int LEVEL_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tu_start,
    input  logic               coef_valid,
    input  logic               cg_first,
    input  logic               coef_last,
    input  logic               is_luma,
    input  logic [3:0]         cg_idx,
    input  logic [LEVEL_W-1:0] abs_level,
    output logic               lvl_start,
    output logic [7:0]         c1_idx,
    output logic [7:0]         c2_idx,
    output logic [1:0]         greater1_ctx,
    output logic [1:0]         ctx_set,
    output logic [LEVEL_W-1:0] abs_level_out,
    output logic               cg_done,
    output logic [4:0]         nz_count,
    output logic               protocol_err
);

    typedef enum logic {IDLE, IN_CG} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t             state_q, state_d;
    logic [7:0]         c1_q, c1_d, c2_q, c2_d;
    logic [1:0]         g1_q, g1_d, ctx_q, ctx_d;
    logic [4:0]         nz_q, nz_d, cnt_q, cnt_d;
    logic               prev_q, prev_d, err_q, err_d;
    logic               lvl_start_q, lvl_start_d, cg_done_q, cg_done_d;
    logic [7:0]         c1o_q, c1o_d, c2o_q, c2o_d;
    logic [1:0]         g1o_q, g1o_d, ctxo_q, ctxo_d;
    logic [LEVEL_W-1:0] lvlo_q, lvlo_d;
    logic [4:0]         nzo_q, nzo_d;

    // Working values: cg_first restarts the CG state in the same cycle.
    logic               accept, nonzero, gt1, prev_eff, full, cg_end;
    logic [7:0]         c1_b, c2_b, c1_n, c2_n;
    logic [1:0]         g1_b, g1_n, ctx_b;
    logic [4:0]         nz_b, nz_n, cnt_n;

    always_comb begin
        accept   = coef_valid && (cg_first || state_q == IN_CG);
        prev_eff = tu_start ? 1'b0 : prev_q;
        nonzero  = (abs_level != '0);
        gt1      = (abs_level > LEVEL_W'(1));

        c1_b  = cg_first ? 8'd0 : c1_q;
        c2_b  = cg_first ? 8'd0 : c2_q;
        g1_b  = cg_first ? 2'd1 : g1_q;
        nz_b  = cg_first ? 5'd0 : nz_q;
        ctx_b = cg_first ? (((cg_idx == 4'd0) || !is_luma) ? 2'd0 : 2'd2) + {1'b0, prev_eff}
                         : ctx_q;

        c1_n = nonzero ? sat_inc8(c1_b) : c1_b;
        c2_n = (nonzero && gt1 && (c1_b < 8'(C1FLAG_NUMBER))) ? sat_inc8(c2_b) : c2_b;
        if (!nonzero)          g1_n = g1_b;
        else if (gt1)          g1_n = 2'd0;
        else if (g1_b == 2'd0) g1_n = 2'd0;
        else if (g1_b == 2'd3) g1_n = 2'd3;
        else                   g1_n = g1_b + 2'd1;
        nz_n   = nonzero ? nz_b + 5'd1 : nz_b;
        cnt_n  = (cg_first ? 5'd0 : cnt_q) + 5'd1;
        full   = (cnt_n == 5'(CG_SIZE));
        cg_end = coef_last || full;

        state_d     = state_q;
        c1_d        = c1_q;
        c2_d        = c2_q;
        g1_d        = g1_q;
        ctx_d       = ctx_q;
        nz_d        = nz_q;
        cnt_d       = cnt_q;
        prev_d      = prev_eff;
        lvl_start_d = 1'b0;
        cg_done_d   = 1'b0;
        c1o_d       = c1o_q;
        c2o_d       = c2o_q;
        g1o_d       = g1o_q;
        ctxo_d      = ctxo_q;
        lvlo_d      = lvlo_q;
        nzo_d       = nzo_q;

        // Stray coefficient in IDLE, CG restart while busy, or a CG that fills
        // without coef_last are all protocol violations.
        err_d = err_q
              | (coef_valid && !cg_first && state_q == IDLE)
              | (coef_valid && cg_first && state_q == IN_CG)
              | (accept && full && !coef_last);

        if (accept) begin
            c1_d    = c1_n;
            c2_d    = c2_n;
            g1_d    = g1_n;
            ctx_d   = ctx_b;
            nz_d    = nz_n;
            cnt_d   = cnt_n;
            state_d = cg_end ? IDLE : IN_CG;
            if (nonzero) begin
                lvl_start_d = 1'b1;
                c1o_d       = c1_b;
                c2o_d       = c2_b;
                g1o_d       = g1_b;
                ctxo_d      = ctx_b;
                lvlo_d      = abs_level;
            end
            if (cg_end) begin
                cg_done_d = 1'b1;
                nzo_d     = nz_n;
                prev_d    = (g1_n == 2'd0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            c1_q        <= '0;
            c2_q        <= '0;
            g1_q        <= '0;
            ctx_q       <= '0;
            nz_q        <= '0;
            cnt_q       <= '0;
            prev_q      <= 1'b0;
            err_q       <= 1'b0;
            lvl_start_q <= 1'b0;
            cg_done_q   <= 1'b0;
            c1o_q       <= '0;
            c2o_q       <= '0;
            g1o_q       <= '0;
            ctxo_q      <= '0;
            lvlo_q      <= '0;
            nzo_q       <= '0;
        end else begin
            state_q     <= state_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            g1_q        <= g1_d;
            ctx_q       <= ctx_d;
            nz_q        <= nz_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            err_q       <= err_d;
            lvl_start_q <= lvl_start_d;
            cg_done_q   <= cg_done_d;
            c1o_q       <= c1o_d;
            c2o_q       <= c2o_d;
            g1o_q       <= g1o_d;
            ctxo_q      <= ctxo_d;
            lvlo_q      <= lvlo_d;
            nzo_q       <= nzo_d;
        end
    end

    assign lvl_start     = lvl_start_q;
    assign c1_idx        = c1o_q;
    assign c2_idx        = c2o_q;
    assign greater1_ctx  = g1o_q;
    assign ctx_set       = ctxo_q;
    assign abs_level_out = lvlo_q;
    assign cg_done       = cg_done_q;
    assign nz_count      = nzo_q;
    assign protocol_err  = err_q;

endmodule

// File: tb/tb_gt1_ctx_tracker.sv
// Self-checking bench for gt1_ctx_tracker: directed CGs from the test plan,
// randomized CGs against a counting-based reference model, and error cases.
module tb_gt1_ctx_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tu_start = 1'b0, coef_valid = 1'b0, cg_first = 1'b0, coef_last = 1'b0;
    logic        is_luma = 1'b0;
    logic [3:0]  cg_idx = '0;
    logic [15:0] abs_level = '0;
    logic        lvl_start, cg_done, protocol_err;
    logic [7:0]  c1_idx, c2_idx;
    logic [1:0]  greater1_ctx, ctx_set;
    logic [15:0] abs_level_out;
    logic [4:0]  nz_count;

    gt1_ctx_tracker #(.C1FLAG_NUMBER(8), .CG_SIZE(16), .LEVEL_W(16)) dut (
        .clk(clk), .rst(rst), .tu_start(tu_start), .coef_valid(coef_valid),
        .cg_first(cg_first), .coef_last(coef_last), .is_luma(is_luma),
        .cg_idx(cg_idx), .abs_level(abs_level), .lvl_start(lvl_start),
        .c1_idx(c1_idx), .c2_idx(c2_idx), .greater1_ctx(greater1_ctx),
        .ctx_set(ctx_set), .abs_level_out(abs_level_out), .cg_done(cg_done),
        .nz_count(nz_count), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    // Event vector layout: {c1[35:28], c2[27:20], g1[19:18], ctx[17:16], level[15:0]}
    typedef struct { longint t; logic [35:0] v; } ev_t;
    typedef struct { longint t; logic [4:0] nz; } done_t;

    ev_t   obs_ev[$], exp_ev[$];
    done_t obs_done[$];
    int    stim_lv[16];
    int    exp_nz;
    bit    m_prev;
    int    n_checks = 0, n_fail = 0;

    always @(posedge clk) begin
        #1;
        if (lvl_start === 1'b1)
            obs_ev.push_back('{$time, {c1_idx, c2_idx, greater1_ctx, ctx_set, abs_level_out}});
        if (cg_done === 1'b1)
            obs_done.push_back('{$time, nz_count});
    end

    task automatic drive(input bit tu, input bit first, input bit last, input bit luma,
                         input int idx, input int lvl);
        @(negedge clk);
        tu_start = tu; coef_valid = 1'b1; cg_first = first; coef_last = last;
        is_luma = luma; cg_idx = 4'(idx); abs_level = 16'(lvl);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        tu_start = 1'b0; coef_valid = 1'b0; cg_first = 1'b0; coef_last = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cg(input bit tu, input bit luma, input int idx, input int n,
                           input bit use_last);
        obs_ev.delete(); obs_done.delete();
        for (int i = 0; i < n; i++)
            drive(tu && i == 0, i == 0, use_last && i == n - 1, luma, idx, stim_lv[i]);
        idle(3);
    endtask

    // Reference: c1 = number of earlier nonzero levels; c2 = number of earlier
    // levels >1 whose own c1 was below 8; greater1 is 0 once any level >1 was
    // seen, otherwise 1 + earlier nonzero count capped at 3. The next CG's
    // ctx_set offset is therefore simply "this CG had a level above 1".
    task automatic model_cg(input bit tu, input bit luma, input int idx, input int n);
        int nzc, c2c, g1; bit big; int ctx;
        if (tu) m_prev = 1'b0;
        ctx = (((idx == 0) || !luma) ? 0 : 2) + int'(m_prev);
        nzc = 0; c2c = 0; big = 1'b0;
        exp_ev.delete();
        for (int i = 0; i < n; i++) begin
            if (stim_lv[i] != 0) begin
                g1 = big ? 0 : ((nzc + 1 > 3) ? 3 : nzc + 1);
                exp_ev.push_back('{0, {8'(nzc > 255 ? 255 : nzc), 8'(c2c), 2'(g1), 2'(ctx),
                                       16'(stim_lv[i])}});
                if (stim_lv[i] > 1) begin
                    if (nzc < 8) c2c++;
                    big = 1'b1;
                end
                nzc++;
            end
        end
        exp_nz = nzc;
        m_prev = big;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({lvl_start, cg_done, protocol_err, c1_idx, c2_idx, greater1_ctx, ctx_set,
             abs_level_out, nz_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got lvl=%b done=%b err=%b c1=%0d c2=%0d g1=%0d ctx=%0d lvl=%0d nz=%0d, expected all 0",
                     lvl_start, cg_done, protocol_err, c1_idx, c2_idx, greater1_ctx, ctx_set,
                     abs_level_out, nz_count);
        end
        rst = 1'b0;
        idle(2);
        n_checks++;
        if ({lvl_start, cg_done, protocol_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release: got lvl=%b done=%b err=%b, expected 000",
                     lvl_start, cg_done, protocol_err);
        end
    endtask

    task automatic test_sequences;
        bit tu, luma; int idx, n;
        m_prev = 1'b0;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin tu = 1; luma = 1; idx = 1; n = 5;
                         stim_lv[0] = 3; stim_lv[1] = 1; stim_lv[2] = 0; stim_lv[3] = 2; stim_lv[4] = 1; end
                1: begin tu = 0; luma = 1; idx = 2; n = 2; stim_lv[0] = 2; stim_lv[1] = 1; end
                2: begin tu = 0; luma = 0; idx = 0; n = 5;
                         for (int i = 0; i < 5; i++) stim_lv[i] = 1; end
                default: begin tu = 0; luma = 1; idx = 3; n = 10;
                         for (int i = 0; i < 10; i++) stim_lv[i] = 2; end
            endcase
            model_cg(tu, luma, idx, n);
            send_cg(tu, luma, idx, n, 1'b1);
            n_checks++;
            if (obs_ev.size() != exp_ev.size()) begin
                n_fail++;
                $display("FAIL seq%0d_pulse_count: got %0d, expected %0d", k, obs_ev.size(), exp_ev.size());
            end else begin
                for (int i = 0; i < exp_ev.size(); i++) begin
                    n_checks++;
                    if (obs_ev[i].v !== exp_ev[i].v) begin
                        n_fail++;
                        $display("FAIL seq%0d_coef%0d {c1,c2,g1,ctx,lvl}: got %h, expected %h",
                                 k, i, obs_ev[i].v, exp_ev[i].v);
                    end
                end
            end
            n_checks++;
            if (obs_done.size() != 1 || obs_done[0].nz !== 5'(exp_nz) ||
                (obs_ev.size() > 0 && obs_done[0].t != obs_ev[obs_ev.size()-1].t)) begin
                n_fail++;
                $display("FAIL seq%0d_cg_done: got %0d pulses nz=%0d, expected 1 pulse nz=%0d with last lvl_start",
                         k, obs_done.size(), obs_done.size() > 0 ? obs_done[0].nz : 5'd0, exp_nz);
            end
            // Spot checks of the documented values, independent of the model.
            n_checks++;
            case (k)
                0: if (obs_ev.size() < 4 || obs_ev[3].v[35:16] !== {8'd3, 8'd2, 2'd0, 2'd2}) begin
                       n_fail++; $display("FAIL plan_cg1_last: got %h, expected c1=3 c2=2 g1=0 ctx=2",
                                          obs_ev.size() > 3 ? obs_ev[3].v : 36'h0);
                   end
                1: if (obs_ev.size() < 1 || obs_ev[0].v[17:16] !== 2'd3) begin
                       n_fail++; $display("FAIL plan_follow_ctx: got %h, expected ctx=3",
                                          obs_ev.size() > 0 ? obs_ev[0].v : 36'h0);
                   end
                2: if (obs_ev.size() < 5 || obs_ev[4].v[35:16] !== {8'd4, 8'd0, 2'd3, 2'd1}) begin
                       n_fail++; $display("FAIL plan_chroma_ones: got %h, expected c1=4 c2=0 g1=3 ctx=1",
                                          obs_ev.size() > 4 ? obs_ev[4].v : 36'h0);
                   end
                default: if (obs_ev.size() < 10 || obs_ev[8].v[27:20] !== 8'd8 ||
                             obs_ev[9].v[35:20] !== {8'd9, 8'd8}) begin
                       n_fail++; $display("FAIL plan_c2_limit: got %h, expected c1=9 c2=8",
                                          obs_ev.size() > 9 ? obs_ev[9].v : 36'h0);
                   end
            endcase
        end
        n_checks++;
        if (protocol_err !== 1'b0) begin
            n_fail++; $display("FAIL seq_no_err: got protocol_err=%b, expected 0", protocol_err);
        end
    endtask

    task automatic test_random;
        bit tu, luma; int idx, n, r;
        for (int k = 0; k < 40; k++) begin
            tu = (k == 0) || ($urandom_range(0, 4) == 0);
            luma = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 15);
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 9);
                stim_lv[i] = (r < 3) ? 0 : (r < 6) ? 1 : (r < 8) ? 2 : (r == 8) ? 3 : $urandom_range(4, 65535);
            end
            model_cg(tu, luma, idx, n);
            send_cg(tu, luma, idx, n, 1'b1);
            n_checks++;
            if (obs_ev.size() != exp_ev.size()) begin
                n_fail++;
                $display("FAIL rnd%0d_pulse_count: got %0d, expected %0d", k, obs_ev.size(), exp_ev.size());
            end else begin
                for (int i = 0; i < exp_ev.size(); i++) begin
                    n_checks++;
                    if (obs_ev[i].v !== exp_ev[i].v) begin
                        n_fail++;
                        $display("FAIL rnd%0d_coef%0d {c1,c2,g1,ctx,lvl}: got %h, expected %h",
                                 k, i, obs_ev[i].v, exp_ev[i].v);
                    end
                end
            end
            n_checks++;
            if (obs_done.size() != 1 || obs_done[0].nz !== 5'(exp_nz)) begin
                n_fail++;
                $display("FAIL rnd%0d_cg_done: got %0d pulses nz=%0d, expected 1 pulse nz=%0d",
                         k, obs_done.size(), obs_done.size() > 0 ? obs_done[0].nz : 5'd0, exp_nz);
            end
        end
        n_checks++;
        if (protocol_err !== 1'b0) begin
            n_fail++; $display("FAIL rnd_no_err: got protocol_err=%b, expected 0", protocol_err);
        end
    endtask

    task automatic test_forced_end;
        for (int i = 0; i < 16; i++) stim_lv[i] = 1;
        send_cg(1'b1, 1'b1, 5, 16, 1'b0);
        n_checks++;
        if (obs_done.size() != 1 || obs_done[0].nz !== 5'd16 || obs_ev.size() != 16) begin
            n_fail++;
            $display("FAIL forced_end: got %0d done pulses nz=%0d, %0d lvl_starts; expected 1, 16, 16",
                     obs_done.size(), obs_done.size() > 0 ? obs_done[0].nz : 5'd0, obs_ev.size());
        end
        n_checks++;
        if (protocol_err !== 1'b1) begin
            n_fail++; $display("FAIL forced_end_err: got %b, expected 1", protocol_err);
        end
    endtask

    task automatic test_idle_err;
        rst = 1'b1; idle(1); rst = 1'b0; idle(1);
        obs_ev.delete(); obs_done.delete();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1, 5);
        idle(3);
        n_checks++;
        if (obs_ev.size() != 0 || obs_done.size() != 0 || protocol_err !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_stray: got %0d lvl_starts %0d dones err=%b, expected 0 0 1",
                     obs_ev.size(), obs_done.size(), protocol_err);
        end
    endtask

    task automatic test_abandon;
        rst = 1'b1; idle(1); rst = 1'b0; idle(1);
        obs_ev.delete(); obs_done.delete();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 2);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1);
        idle(3);
        n_checks++;
        if (obs_ev.size() != 4 || obs_ev[2].v[35:18] !== {8'd0, 8'd0, 2'd1} ||
            obs_ev[3].v[35:18] !== {8'd1, 8'd0, 2'd2}) begin
            n_fail++;
            $display("FAIL abandon_restart: got %0d pulses, expected 4 with restart at c1=0 g1=1",
                     obs_ev.size());
        end
        n_checks++;
        if (obs_done.size() != 1 || obs_done[0].nz !== 5'd2 || protocol_err !== 1'b1) begin
            n_fail++;
            $display("FAIL abandon_done: got %0d dones err=%b, expected 1 done nz=2 err=1",
                     obs_done.size(), protocol_err);
        end
    endtask

    task automatic test_rst_mid;
        rst = 1'b1; idle(1); rst = 1'b0; idle(1);
        obs_ev.delete(); obs_done.delete();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2, 2);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2, 1);
        @(negedge clk);
        coef_valid = 1'b0; cg_first = 1'b0; tu_start = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({lvl_start, cg_done, protocol_err, c1_idx, c2_idx, greater1_ctx, ctx_set,
             abs_level_out, nz_count} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got lvl=%b c1=%0d c2=%0d g1=%0d ctx=%0d lvl=%0d, expected all 0",
                     lvl_start, c1_idx, c2_idx, greater1_ctx, ctx_set, abs_level_out);
        end
        idle(1);
        rst = 1'b0;
        idle(4);
        n_checks++;
        if (obs_done.size() != 0 || obs_ev.size() != 3) begin
            n_fail++;
            $display("FAIL rst_mid_no_done: got %0d dones %0d lvl_starts, expected 0 and 3",
                     obs_done.size(), obs_ev.size());
        end
    endtask

    initial begin
        test_reset();
        test_sequences();
        test_random();
        test_forced_end();
        test_idle_err();
        test_abandon();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gt1_ctx_tracker.md
Name: gt1_ctx_tracker

Overview:
- Per-coefficient-group (CG) sequencer that sits directly upstream of the base-level calculator in the CABAC rate estimator.
- Accepts absolute coefficient levels of one 4x4 CG in reverse scan order. For every nonzero coefficient it emits the c1/c2 indices and the greater1 context state, plus a one-cycle start pulse that triggers base-level calculation.
- Carries the previous-CG greater1 state across CGs within a transform unit (TU) to derive ctx_set.

Parameters:
- C1FLAG_NUMBER, 8, max greater1 flags coded per CG; c2 index advances only while c1_idx < this value.
- CG_SIZE, 16, max coefficients per CG.
- LEVEL_W, 16, width of absolute level.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- tu_start  in  1  pulse; marks a new TU and sets prev_c1_zero to 0; may coincide with cg_first
- coef_valid  in  1  coefficient present this cycle; no backpressure, one per cycle max
- cg_first  in  1  qualifies coef_valid; first coefficient of a CG
- coef_last  in  1  qualifies coef_valid; last coefficient of a CG
- is_luma  in  1  sampled with cg_first
- cg_idx  in  4  CG index in TU, sampled with cg_first
- abs_level  in  LEVEL_W  absolute coefficient level
- lvl_start  out  1  one-cycle pulse per nonzero coefficient; drives base-level start
- c1_idx  out  8  c1 index of this coefficient
- c2_idx  out  8  c2 index of this coefficient
- greater1_ctx  out  2  greater1 context state (0..3)
- ctx_set  out  2  context set for this CG
- abs_level_out  out  LEVEL_W  level of the coefficient being emitted
- cg_done  out  1  one-cycle pulse at CG end
- nz_count  out  5  nonzero coefficients in the finished CG; valid with cg_done
- protocol_err  out  1  sticky error flag; cleared only by rst

Behaviour:
- Reset: all outputs 0; state IDLE; prev_c1_zero = 0; all counters 0.
- States:
  - IDLE: coef_valid without cg_first is ignored and sets protocol_err.
  - IN_CG: active while processing a CG.
- cg_first accepted (any state):
  - c1_idx_r = 0, c2_idx_r = 0, g1ctx_r = 1, nz = 0, cnt = 0.
  - ctx_set_r = ((cg_idx == 0 || !is_luma) ? 0 : 2) + prev_c1_zero, using prev_c1_zero after any same-cycle tu_start clear.
  - Go to IN_CG.
- cg_first while in IN_CG: current CG is abandoned, no cg_done is issued, protocol_err is set, and the new CG starts.
- Per accepted coefficient (cnt increments):
  - If abs_level == 0: no output.
  - If abs_level != 0, next cycle (latency 1, registered):
    - lvl_start = 1.
    - c1_idx, c2_idx, greater1_ctx are the pre-update state; ctx_set, abs_level_out are those of this coefficient.
  - State update for a nonzero coefficient:
    - c1_idx_r + 1, saturating at 255.
    - If abs_level > 1 and c1_idx_r < C1FLAG_NUMBER: c2_idx_r + 1, saturating at 255.
    - g1ctx: if abs_level > 1 then 0; else if g1ctx != 0 then min(g1ctx + 1, 3).
    - nz + 1.
- CG end: coef_last, or the CG_SIZE-th coefficient.
  - cg_done and nz_count are valid the cycle after; cg_done is coincident with the last lvl_start if that coefficient was nonzero.
  - prev_c1_zero = (final g1ctx == 0).
  - Return to IDLE.
  - If the CG_SIZE-th coefficient arrives without coef_last: forced end and protocol_err set.
- cg_first and coef_last on the same coefficient: single-coefficient CG.
- lvl_start, cg_done deassert the cycle after their pulse; data outputs hold their last values.
- rst mid-CG: immediate return to IDLE; no pulses; partial CG discarded.

Test Plan:
- CG, luma, cg_idx = 1, after tu_start; levels 3, 1, 0, 2, 1 (last):
  - lvl_start x4 with (c1, c2, g1ctx) = (0,0,1), (1,1,0), (2,1,0), (3,2,0).
  - ctx_set = 2; the zero is skipped; cg_done with nz_count = 4.
- Follow-on CG, luma, cg_idx = 2 (prev final g1ctx = 0):
  - ctx_set = 3.
  - Chroma CG afterwards with g1ctx ending at 0 gives ctx_set = 1.
- Levels 1, 1, 1, 1, 1: greater1_ctx sequence 1, 2, 3, 3, 3; c2_idx stays 0.
- Ten levels of 2:
  - c1_idx 0..9.
  - c2_idx 0..7, then 8, 8 (no increment once c1_idx >= 8).
- Error cases:
  - 16 coefficients without coef_last: forced cg_done, nz_count = 16, protocol_err = 1.
  - coef_valid in IDLE without cg_first: ignored, protocol_err = 1.
  - rst asserted after 3 coefficients: outputs 0, no cg_done.
